// File: rtl/onehot_stream_checker_if.sv
// Valid/ready bundle for the onehot stream checker:
// vector beats in, popcount/onehot results out.
interface onehot_stream_checker_if #(
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             out_onehot;
    logic             out_onehot0;
    logic             out_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_count,
        input  out_onehot,
        input  out_onehot0,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_count,
        output out_onehot,
        output out_onehot0,
        output out_last
    );
endinterface

// File: rtl/onehot_stream_checker.sv
// Two-stage popcount / onehot checker with per-frame
// saturating statistics delimited by in_last.
module onehot_stream_checker #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    onehot_stream_checker_if.slave bus,
    output logic [ACC_W-1:0]      frame_total,
    output logic [ACC_W-1:0]      frame_viol,
    output logic                  frame_done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = ((ACC_W > CW) ? ACC_W : CW) + 1;
    localparam logic [SW-1:0] ACC_MAX =
        (SW'(1) << ACC_W) - SW'(1);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic             s1_last;
    logic [CW-1:0]    s1_count;

    logic             out_valid;
    logic [CW-1:0]    out_count;
    logic             out_onehot;
    logic             out_onehot0;
    logic             out_last;

    logic [ACC_W-1:0] acc_total;
    logic [ACC_W-1:0] acc_viol;
    logic [SW-1:0]    sum_total;
    logic [SW-1:0]    sum_viol;
    logic [ACC_W-1:0] nxt_total;
    logic [ACC_W-1:0] nxt_viol;

    logic s2_en;
    logic s1_en;
    logic in_ready;
    logic in_fire;
    logic out_fire;

    assign s2_en    = !out_valid || bus.out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en && !clear;
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid && bus.out_ready && !clear;

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_count   = out_count;
    assign bus.out_onehot  = out_onehot;
    assign bus.out_onehot0 = out_onehot0;
    assign bus.out_last    = out_last;

    always_comb begin
        s1_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s1_count = s1_count + CW'(s1_data[i]);
        end
    end

    // Wide sums so a carry out of ACC_W bits saturates.
    always_comb begin
        sum_total = SW'(acc_total) + SW'(out_count);
        sum_viol  = SW'(acc_viol) + SW'(!out_onehot0);
        nxt_total = (sum_total > ACC_MAX) ?
                    '1 : sum_total[ACC_W-1:0];
        nxt_viol  = (sum_viol > ACC_MAX) ?
                    '1 : sum_viol[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_last  <= 1'b0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_data <= bus.in_data;
                s1_last <= bus.in_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_count   <= '0;
            out_onehot  <= 1'b0;
            out_onehot0 <= 1'b0;
            out_last    <= 1'b0;
        end else if (clear) begin
            out_valid   <= 1'b0;
            out_count   <= '0;
            out_onehot  <= 1'b0;
            out_onehot0 <= 1'b0;
            out_last    <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_count   <= s1_count;
                out_onehot  <= (s1_count == CW'(1));
                out_onehot0 <= (s1_count <= CW'(1));
                out_last    <= s1_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_total   <= '0;
            acc_viol    <= '0;
            frame_total <= '0;
            frame_viol  <= '0;
            frame_done  <= 1'b0;
        end else if (clear) begin
            acc_total   <= '0;
            acc_viol    <= '0;
            frame_total <= '0;
            frame_viol  <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= out_fire && out_last;
            if (out_fire) begin
                if (out_last) begin
                    frame_total <= nxt_total;
                    frame_viol  <= nxt_viol;
                    acc_total   <= '0;
                    acc_viol    <= '0;
                end else begin
                    acc_total <= nxt_total;
                    acc_viol  <= nxt_viol;
                end
            end
        end
    end
endmodule

// File: doc/onehot_stream_checker.md
# onehot_stream_checker

- Pipelined checker stage that sits downstream of a grant/select generator.
- It accepts a stream of bit-vectors over a valid/ready handshake.
- For each vector it reports the population count plus onehot and onehot0 flags.
- It also keeps per-frame statistics: total set bits and the number of onehot0 violations, delimited by `in_last`.

## Interface
Parameters:
- WIDTH, 16: bits per input vector (≥1).
- ACC_W, 16: width of frame accumulators (≥4).
- CW, derived = $clog2(WIDTH+1): width of count output (1 when WIDTH=1).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- clear  in  1  synchronous flush of pipeline and accumulators.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  WIDTH  vector under test.
- in_last  in  1  beat is last of frame.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- out_count  out  CW  number of set bits in vector.
- out_onehot  out  1  exactly one bit set.
- out_onehot0  out  1  zero or one bit set.
- out_last  out  1  copy of in_last for this beat.
- frame_total  out  ACC_W  saturating sum of out_count over last completed frame.
- frame_viol  out  ACC_W  saturating count of beats with out_onehot0=0 in last completed frame.
- frame_done  out  1  one-cycle pulse when frame_total/frame_viol update.

## Operation
- Stage 1 (S1) registers in_data and in_last on input transfer.
- Stage 2 (S2) registers the computed count and flags, and drives out_*.
- Enables:
  - s2_en = !out_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en && !clear
- Full throughput: one beat per cycle when out_ready is held high.
- Backpressure: with out_ready low and both stages full, in_ready=0; data in S1/S2 is held unchanged.
- Arithmetic: count uses CW bits with no overflow.
  - onehot = (count==1)
  - onehot0 = (count<=1)
  - WIDTH=1: onehot = in bit; onehot0 = 1 always.
- Accumulators acc_total and acc_viol (ACC_W bits, internal) update only on an output transfer (out_valid && out_ready):
  - Non-last beat: acc_total += out_count and acc_viol += !out_onehot0, each saturating at all-ones.
  - Last beat:
    - frame_total and frame_viol are loaded with the acc values plus this beat's contribution (saturating).
    - acc_total and acc_viol are zeroed.
    - frame_done=1 for the next cycle.
- A single-beat frame (in_last on the first beat) is legal.
- frame_total and frame_viol hold their values until the next frame completes.
- clear (synchronous, highest priority):
  - S1 and S2 are invalidated and in-flight beats are dropped.
  - acc_*, frame_total, frame_viol and frame_done are zeroed.
  - Any transfer on that cycle is ignored.

## Timing
- Reset values (rst_n low, asynchronous):
  - out_valid=0, out_count=0, out_onehot=0, out_onehot0=0, out_last=0.
  - frame_total=0, frame_viol=0, frame_done=0.
  - S1 invalid; acc_*=0.
  - in_ready=1 from the first edge after reset deasserts.
- Latency: a beat accepted at edge N has out_valid=1 after edge N+1 (2-cycle in→out), with no stall.
- frame_done asserts in the cycle after the edge where the last beat transfers out, and lasts exactly one cycle.
- frame_total and frame_viol change on that same edge.
- Simultaneous output transfer and input accept in one cycle: both occur, and the pipeline shifts.
- out_* are stable while out_valid=1 and out_ready=0.
- Reset mid-frame discards the partial accumulation; no frame_done is produced.

## Test plan
- **Basic, WIDTH=8, out_ready=1:** send 0x00, 0x04, 0xAA, 0xF0(last).
  - Outputs (count/onehot/onehot0): 0/0/1, 1/1/1, 4/0/0, 4/0/0.
  - Then frame_done pulses with frame_total=9, frame_viol=2.
  - First out_valid appears 2 cycles after the first accept.
- **Backpressure:** stream 6 beats with out_ready toggling 1,0,0,1.
  - No beat is lost or duplicated and the output order matches the input.
  - in_ready is 0 whenever S1 and S2 are full and out_ready=0.
  - out_* stay stable while stalled.
- **Saturation, ACC_W=4, WIDTH=8:** send a 3-beat frame of 0xFF.
  - Expect frame_total=15 (saturated), frame_viol=3.
- **Single-beat frames:** 0x01(last) then 0x00(last).
  - Two frame_done pulses: first with frame_total=1, frame_viol=0; second with frame_total=0, frame_viol=0.
- **clear mid-frame:** send two non-last beats, assert clear for one cycle, then send 0x03(last).
  - The dropped beats never appear on out_*.
  - Expect frame_total=2, frame_viol=1.
- **Async reset:** pulse rst_n low asynchronously mid-stream with out_valid=1.
  - All outputs are 0 immediately.
  - After release, a new frame accumulates from zero.
